fifo_stream_out: RTL

FIFO_STREAM_OUT -- requirements
Module: fifo_stream_out

---
 rtl/fifo_pkg.sv | 17 +
 rtl/stream_buf2.sv | 78 +++++++
 rtl/fifo_stream_out.sv | 73 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Purpose: shared constants and types for the FIFO-to-stream read path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: default data width, skid-buffer depth, occupancy type.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 4;

  // Depth of the output buffer. Together with the 1-cycle FIFO read
  // latency this is the minimum that sustains one word per cycle.
  localparam int BUF_DEPTH = 2;

  // Buffer occupancy, 0..BUF_DEPTH.
  typedef logic [1:0] occ_t;

endpackage

// File: rtl/stream_buf2.sv
// Purpose: 2-entry in-order buffer; head entry drives the stream outputs.
// Latency: push visible at head the cycle after the push edge if empty.
// Backpressure: caller must not push when full unless popping the same cycle.
//
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   push_i       - write push_dat_i at the tail this cycle
//   pop_i        - remove the head entry this cycle (ignored when empty)
//   head_dat_o   - head entry, straight from a register
//   head_vld_o   - buffer non-empty
//   count_o      - current occupancy
module stream_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_dat_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_dat_o,
  output logic                  head_vld_o,
  output occ_t                  count_o
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;  // head
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;  // second entry
  occ_t                  count_q, count_d;
  logic                  pop_ok;

  assign pop_ok = pop_i && (count_q != 2'd0);

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    case ({push_i, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) ent0_d = push_dat_i;
        else                 ent1_d = push_dat_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        ent1_d  = '0;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged: the new word lands behind whatever remains.
        if (count_q == 2'd1) begin
          ent0_d = push_dat_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_dat_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign head_dat_o = ent0_q;
  assign head_vld_o = (count_q != 2'd0);
  assign count_o    = count_q;

endmodule

// File: rtl/fifo_stream_out.sv
// Purpose: drain a latency-1 FIFO read port into a valid/ready stream.
// Latency: pop edge N -> capture at edge N+1 -> m_valid right after it.
// Backpressure: pops only with buffer credit; m_ready=0 holds m_data/m_valid.
//
// Ports:
//   clk, rst_n               - clock (shared with FIFO read side), sync active-low reset
//   fifo_rd_data/_empty/_en  - FIFO read port (data valid one cycle after a pop)
//   m_data/m_valid/m_ready   - output stream
//   word_cnt                 - number of words transferred, wraps
module fifo_stream_out
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  occ_t                 count;
  logic                 xfer;
  logic [2:0]           credit;

  assign xfer = m_valid && m_ready;

  // Slots free after this edge: in-flight words already own a slot, and a
  // word leaving this cycle frees one. count+inflight <= BUF_DEPTH keeps
  // this from going negative.
  assign credit = 3'(BUF_DEPTH) - {1'b0, count} - {2'b00, inflight_q}
                  + {2'b00, xfer};

  // rst_n is folded in so no pop is accepted while the shared FIFO resets.
  assign fifo_rd_en = !fifo_rd_empty && (credit != 3'd0) && rst_n;

  assign inflight_d = fifo_rd_en;
  assign word_cnt_d = xfer ? word_cnt_q + CNT_WIDTH'(1) : word_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // The word popped last cycle is on fifo_rd_data now; capture it.
  stream_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_dat_i (fifo_rd_data),
    .pop_i      (xfer),
    .head_dat_o (m_data),
    .head_vld_o (m_valid),
    .count_o    (count)
  );

  assign word_cnt = word_cnt_q;

endmodule
